// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared defaults and sizing helpers for the add_arb round-robin
// adder arbiter. Imported by add_arb and add_arb_rr.
package add_arb_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int W_DEFAULT     = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage : add_arb_pkg

// File: rtl/add_arb_rr.sv
// add_arb_rr: purely combinational round-robin picker. Searches the request
// vector starting at ptr_i and wrapping modulo N_REQ; reports the first hit as
// a one-hot grant, its index, and whether anything was found at all.
module add_arb_rr
    import add_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int ID_W  = id_w(N_REQ_DEFAULT)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Candidate gi is the requester gi places after the pointer, wrapped.
    logic [ID_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_vld;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            // One extra bit so ptr + offset cannot overflow before the wrap.
            logic [ID_W:0] raw_sum;
            assign raw_sum = {1'b0, ptr_i} + (ID_W+1)'(gi);
            assign cand_idx[gi] = (raw_sum >= (ID_W+1)'(N_REQ))
                                ? ID_W'(raw_sum - (ID_W+1)'(N_REQ))
                                : raw_sum[ID_W-1:0];
            assign cand_vld[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    // First valid candidate in rotated order wins.
    always_comb begin
        logic found;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && cand_vld[i]) begin
                found = 1'b1;
                idx_o = cand_idx[i];
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule : add_arb_rr

// File: rtl/add_arb.sv
// add_arb: shares one registered W-bit adder among N_REQ requesters.
// A round-robin picker grants one requester per cycle whenever the single
// output slot is free (empty, or being drained this cycle); the sum appears on
// the response bus one cycle after the accept, tagged by a one-hot valid.
// Optional feature: define ADD_ARB_CARRY_EN to register the adder carry-out and
// expose it on o_rsp_carry.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic               ck,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_vld,
    input  logic [N_REQ*W-1:0] i_req_a,
    input  logic [N_REQ*W-1:0] i_req_b,
    output logic [N_REQ-1:0]   o_req_rdy,
    output logic [N_REQ-1:0]   o_rsp_vld,
    output logic [W-1:0]       o_rsp_res,
`ifdef ADD_ARB_CARRY_EN
    output logic               o_rsp_carry,
`endif
    input  logic [N_REQ-1:0]   i_rsp_rdy
);

    localparam int ID_W = id_w(N_REQ);

    // Output slot record: everything the consumer sees, held in one register.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] owner;
        logic [W-1:0]    res;
`ifdef ADD_ARB_CARRY_EN
        logic            carry;
`endif
    } slot_t;

    slot_t           slot_q, slot_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Operand buses split into per-requester words for indexed selection.
    logic [W-1:0] a_arr [N_REQ];
    logic [W-1:0] b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = i_req_a[gi*W +: W];
            assign b_arr[gi] = i_req_b[gi*W +: W];
        end
    endgenerate

    logic [N_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]  rr_idx;
    logic             rr_any;

    add_arb_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i (i_req_vld),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // The slot can take a new result if it is empty or its owner drains now.
    logic slot_free;
    logic accept;
    logic drain;

    assign slot_free = !slot_q.vld | i_rsp_rdy[slot_q.owner];
    assign drain     = slot_q.vld & i_rsp_rdy[slot_q.owner];
    // Reset gates the grant so nothing is accepted while in reset.
    assign accept    = i_rst_n & slot_free & rr_any;
    assign o_req_rdy = accept ? rr_gnt : '0;

    logic [W-1:0] op_a, op_b;
    assign op_a = a_arr[rr_idx];
    assign op_b = b_arr[rr_idx];

`ifdef ADD_ARB_CARRY_EN
    logic [W:0] sum_full;
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};
`else
    logic [W-1:0] sum_full;
    assign sum_full = op_a + op_b;
`endif

    // Next slot/pointer: a new accept overwrites the slot (even while it
    // drains), otherwise a drain just clears the valid bit.
    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        if (accept) begin
            slot_d.vld   = 1'b1;
            slot_d.owner = rr_idx;
            slot_d.res   = sum_full[W-1:0];
`ifdef ADD_ARB_CARRY_EN
            slot_d.carry = sum_full[W];
`endif
            ptr_d = (rr_idx == ID_W'(N_REQ-1)) ? '0 : rr_idx + 1'b1;
        end else if (drain) begin
            slot_d.vld = 1'b0;
        end
    end

    // State registers with synchronous active-low reset discarding the slot.
    always_ff @(posedge ck) begin
        if (!i_rst_n) begin
            slot_q <= '0;
            ptr_q  <= '0;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
        end
    end

    localparam logic [N_REQ-1:0] OH_BASE = {{(N_REQ-1){1'b0}}, 1'b1};

    assign o_rsp_vld = slot_q.vld ? (OH_BASE << slot_q.owner) : '0;
    assign o_rsp_res = slot_q.res;
`ifdef ADD_ARB_CARRY_EN
    assign o_rsp_carry = slot_q.carry;
`endif

endmodule : add_arb

// File: tb/tb_add_arb.sv
// tb_add_arb: scoreboard bench for add_arb. A driver applies stimulus on the
// falling edge, predicts the grant from the round-robin rules and pushes the
// expected response; a monitor compares the response bus every cycle against
// the head of the queue and pops it on each response handshake.
module tb_add_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           ck = 1'b0;
    logic           i_rst_n = 1'b0;
    logic [N-1:0]   i_req_vld = '0;
    logic [N*W-1:0] i_req_a = '0;
    logic [N*W-1:0] i_req_b = '0;
    logic [N-1:0]   o_req_rdy;
    logic [N-1:0]   o_rsp_vld;
    logic [W-1:0]   o_rsp_res;
    logic [N-1:0]   i_rsp_rdy = '0;
`ifdef ADD_ARB_CARRY_EN
    logic           o_rsp_carry;
`endif

    always #5 ck = ~ck;

    add_arb #(.N_REQ(N), .W(W)) dut (
        .ck          (ck),
        .i_rst_n     (i_rst_n),
        .i_req_vld   (i_req_vld),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_req_rdy   (o_req_rdy),
        .o_rsp_vld   (o_rsp_vld),
        .o_rsp_res   (o_rsp_res),
`ifdef ADD_ARB_CARRY_EN
        .o_rsp_carry (o_rsp_carry),
`endif
        .i_rsp_rdy   (i_rsp_rdy)
    );

    typedef struct {
        int           owner;
        logic [W-1:0] res;
        bit           carry;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           m_ptr = 0;
    logic [W-1:0] last_res = '0;
    bit           mon_en = 1'b0;
    bit           auto_ops = 1'b0;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    logic [N-1:0] pend = '0;
    exp_t         mon_e;
    logic [N-1:0] mon_oh;
    logic [N-1:0] rv;
    logic [N-1:0] rr;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endtask

    // One bus cycle: drive, predict grant, check it, update the model.
    task automatic step(input logic rst_n, input logic [N-1:0] vld,
                        input logic [N-1:0] rsp_rdy);
        logic [N-1:0] exp_gnt;
        int           k;
        longint       s;
        exp_t         e;
        @(negedge ck);
        i_rst_n   = rst_n;
        i_req_vld = vld;
        i_rsp_rdy = rsp_rdy;
        for (int j = 0; j < N; j++) begin
            i_req_a[j*W +: W] = a_v[j];
            i_req_b[j*W +: W] = b_v[j];
        end
        #2;
        // Monitor has already retired a draining response, so an empty queue
        // means the slot is free this cycle.
        exp_gnt = '0;
        k = -1;
        if (rst_n && exp_q.size() == 0) begin
            for (int j = 0; j < N; j++) begin
                if (k < 0 && vld[(m_ptr + j) % N]) k = (m_ptr + j) % N;
            end
        end
        if (k >= 0) exp_gnt[k] = 1'b1;
        chk(o_req_rdy == exp_gnt, "req_rdy", 64'(o_req_rdy), 64'(exp_gnt));
        if (!rst_n) begin
            exp_q.delete();
            m_ptr    = 0;
            last_res = '0;
        end else if (k >= 0) begin
            s = longint'(a_v[k]) + longint'(b_v[k]);
            e.owner = k;
            e.res   = W'(s % (longint'(1) << W));
            e.carry = (s >= (longint'(1) << W));
            exp_q.push_back(e);
            last_res = e.res;
            m_ptr = (k + 1) % N;
            if (auto_ops) begin
                a_v[k] = $urandom;
                b_v[k] = $urandom;
            end
        end
        pend = vld & ~exp_gnt;
    endtask

    // Monitor: compare the response bus against the scoreboard every cycle.
    initial begin
        forever begin
            @(negedge ck);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk(o_rsp_vld == '0, "rsp_vld_idle", 64'(o_rsp_vld), 64'(0));
                    chk(o_rsp_res == last_res, "rsp_res_idle", 64'(o_rsp_res), 64'(last_res));
                end else begin
                    mon_e  = exp_q[0];
                    mon_oh = '0;
                    mon_oh[mon_e.owner] = 1'b1;
                    chk(o_rsp_vld == mon_oh, "rsp_vld", 64'(o_rsp_vld), 64'(mon_oh));
                    chk(o_rsp_res == mon_e.res, "rsp_res", 64'(o_rsp_res), 64'(mon_e.res));
`ifdef ADD_ARB_CARRY_EN
                    chk(o_rsp_carry == mon_e.carry, "rsp_carry", 64'(o_rsp_carry), 64'(mon_e.carry));
`endif
                    if (i_rsp_rdy[mon_e.owner]) begin
                        $display("rsp owner=%0d res=0x%08h t=%0t", mon_e.owner, mon_e.res, $time);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int j = 0; j < N; j++) begin
            a_v[j] = '0;
            b_v[j] = '0;
        end
        // Reset for three cycles, then enable the monitor.
        repeat (3) step(1'b0, 4'b0000, 4'b0000);
        mon_en = 1'b1;

        // Single request from requester 2.
        a_v[2] = 32'd5;
        b_v[2] = 32'd7;
        step(1'b1, 4'b0100, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // Wrap-around sum on requester 3 (pointer returns to 0 afterwards).
        a_v[3] = 32'hFFFF_FFFF;
        b_v[3] = 32'd2;
        step(1'b1, 4'b1000, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // All valid, consumer always ready: rotation 0,1,2,3,0 with no bubbles.
        auto_ops = 1'b1;
        for (int j = 0; j < N; j++) begin
            a_v[j] = $urandom;
            b_v[j] = $urandom;
        end
        repeat (5) step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // Backpressure on requester 1, then drain and accept together.
        step(1'b1, 4'b0010, 4'b1111);
        repeat (4) step(1'b1, 4'b1111, 4'b1101);
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // Reset while a result is stalled; first grant goes to lowest index.
        step(1'b1, 4'b0001, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        step(1'b1, 4'b1010, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // Randomized traffic with held requests, edge operands and occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!pend[j]) begin
                    a_v[j] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                    b_v[j] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                end
            end
            rv = pend | N'($urandom);
            rr = N'($urandom) | N'($urandom);
            step(($urandom_range(0, 49) != 0), rv, rr);
        end

        repeat (3) step(1'b1, 4'b0000, 4'b1111);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_add_arb
